// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler for a bank of four data FIFOs feeding one registered output.
// One pop per cycle at most; popped words surface on data_out two cycles after the pop.
module fifo_rr_scheduler #(
    parameter int tamano_datos = 10,
    parameter int num_fifos    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [num_fifos-1:0]              fifo_empty,
    input  logic [num_fifos-1:0]              fifo_error,
    input  logic [num_fifos*tamano_datos-1:0] fifo_data,
    input  logic [num_fifos-1:0]              channel_enable,
    input  logic                              down_almost_full,
    output logic [num_fifos-1:0]              read_enable,
    output logic [tamano_datos-1:0]           data_out,
    output logic                              valid_out,
    output logic [1:0]                        sel,
    output logic                              error_out,
    output logic [1:0]                        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_rr_ptr;
    logic                    r_v1;
    logic [1:0]              r_s1;
    logic [num_fifos-1:0]    w_request;
    logic                    w_any_req;
    logic [1:0]              w_grant;
    logic                    w_pop;
    logic [tamano_datos-1:0] w_word;

    assign w_request = ~fifo_empty & channel_enable;
    assign w_any_req = |w_request;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        w_grant = r_rr_ptr;
        found   = 1'b0;
        for (int k = 0; k < num_fifos; k++) begin
            idx = r_rr_ptr + 2'(k);
            if (!found && w_request[idx]) begin
                w_grant = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        read_enable = '0;
        if (r_state == ACTIVE && !down_almost_full && w_any_req) begin
            read_enable[w_grant] = 1'b1;
        end
    end

    assign w_pop = |read_enable;

    always_comb begin
        w_state_nxt = r_state;
        if (|fifo_error) begin
            w_state_nxt = ERROR;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        w_state_nxt = down_almost_full ? STALL : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (down_almost_full) begin
                        w_state_nxt = STALL;
                    end else if (!w_any_req) begin
                        w_state_nxt = IDLE;
                    end
                end
                STALL: begin
                    if (!down_almost_full) begin
                        w_state_nxt = w_any_req ? ACTIVE : IDLE;
                    end
                end
                ERROR: begin
                    w_state_nxt = ERROR;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_pop) begin
            r_rr_ptr <= w_grant + 2'd1;
        end
    end

    // The FIFO presents the popped word one cycle after the pop, so the mux uses the delayed grant.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < num_fifos; i++) begin
            if (r_s1 == 2'(i)) begin
                w_word = fifo_data[i*tamano_datos +: tamano_datos];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_s1      <= 2'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
            sel       <= 2'd0;
        end else begin
            r_v1      <= w_pop;
            r_s1      <= w_grant;
            valid_out <= r_v1;
            if (r_v1) begin
                data_out <= w_word;
                sel      <= r_s1;
            end
        end
    end

    assign state     = r_state;
    assign error_out = (r_state == ERROR);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: behavioural FIFO bank, scoreboard of expected {sel, word}
// pairs, and directed checks of the pop pattern, latency, stall, error and reset behaviour.
module tb_fifo_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  fifo_empty;
    logic [3:0]  fifo_error = 4'd0;
    logic [39:0] fifo_data;
    logic [3:0]  channel_enable = 4'd0;
    logic        down_almost_full = 1'b0;
    logic [3:0]  read_enable;
    logic [9:0]  data_out;
    logic        valid_out;
    logic [1:0]  sel;
    logic        error_out;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_q[$];
    logic        sb_en = 1'b0;

    // FIFO bank model
    logic [9:0] mem [4][8];
    logic [2:0] wp [4];
    logic [2:0] rp [4];
    logic [3:0] cnt [4];
    logic [9:0] dout [4];
    logic [3:0] wr = 4'd0;
    logic [9:0] wdata [4];
    logic       flush = 1'b1;
    logic       bad_rd = 1'b0;

    fifo_rr_scheduler #(.tamano_datos(10), .num_fifos(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_error       (fifo_error),
        .fifo_data        (fifo_data),
        .channel_enable   (channel_enable),
        .down_almost_full (down_almost_full),
        .read_enable      (read_enable),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .sel              (sel),
        .error_out        (error_out),
        .state            (state)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]           = (cnt[i] == 4'd0);
            fifo_data[i*10 +: 10]   = dout[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush) begin
                wp[i]  <= 3'd0;
                rp[i]  <= 3'd0;
                cnt[i] <= 4'd0;
            end else begin
                if (wr[i]) begin
                    mem[i][wp[i]] <= wdata[i];
                    wp[i]         <= wp[i] + 3'd1;
                end
                if (read_enable[i] && cnt[i] != 4'd0) begin
                    dout[i] <= mem[i][rp[i]];
                    rp[i]   <= rp[i] + 3'd1;
                end
                if (read_enable[i] && cnt[i] == 4'd0) bad_rd <= 1'b1;
                cnt[i] <= cnt[i] + {3'd0, wr[i]} - {3'd0, (read_enable[i] && cnt[i] != 4'd0)};
            end
        end
        if ($countones(read_enable) > 1) bad_rd <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && !reset && valid_out) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_word", {20'd0, sel, data_out}, 32'hFFF);
            end else begin
                check("sb_word", {20'd0, sel, data_out}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [9:0] mkw(input int f, input int w);
        return 10'(256 + f * 16 + w);
    endfunction

    // Called at a negedge; writes one word into FIFO f at the next posedge.
    task automatic put(input int f, input logic [9:0] d);
        wr       = 4'd0;
        wr[f]    = 1'b1;
        wdata[f] = d;
        @(negedge clk);
        wr = 4'd0;
    endtask

    task automatic load_all(input int nwords);
        for (int w = 0; w < nwords; w++)
            for (int f = 0; f < 4; f++) put(f, mkw(f, w));
    endtask

    task automatic wait_re(input string tag);
        int n;
        n = 0;
        while (read_enable == 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, {31'd0, read_enable != 4'd0}, 32'd1);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        flush            = 1'b1;
        channel_enable   = 4'd0;
        down_almost_full = 1'b0;
        fifo_error       = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_err", {31'd0, error_out}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic saw2;
        for (int i = 0; i < 4; i++) wdata[i] = 10'd0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_re", {28'd0, read_enable}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", {22'd0, data_out}, 32'd0);
        check("rst_sel", {30'd0, sel}, 32'd0);
        check("rst_state0", {30'd0, state}, 32'd0);
        check("rst_err0", {31'd0, error_out}, 32'd0);
        reset = 1'b0;
        flush = 1'b0;

        // Test 1: asynchronous reset mid-burst
        for (int w = 0; w < 3; w++) begin
            put(0, mkw(0, w));
            put(1, mkw(1, w));
        end
        channel_enable = 4'hF;
        wait_re("t1");
        @(negedge clk);
        @(negedge clk);
        check("t1_pre_valid", {31'd0, valid_out}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t1_async_re", {28'd0, read_enable}, 32'd0);
        check("t1_async_data", {22'd0, data_out}, 32'd0);
        check("t1_async_valid", {31'd0, valid_out}, 32'd0);
        check("t1_async_sel", {30'd0, sel}, 32'd0);
        check("t1_async_state", {30'd0, state}, 32'd0);
        check("t1_async_err", {31'd0, error_out}, 32'd0);
        flush = 1'b1;
        channel_enable = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t1_no_valid", {31'd0, valid_out}, 32'd0);
        end
        sb_en = 1'b1;

        // Test 2: FIFO 2 alone, three words
        put(2, 10'h091);
        put(2, 10'h04A);
        put(2, 10'h093);
        exp_q.push_back({2'd2, 10'h091});
        exp_q.push_back({2'd2, 10'h04A});
        exp_q.push_back({2'd2, 10'h093});
        channel_enable = 4'hF;
        wait_re("t2");
        check("t2_re0", {28'd0, read_enable}, 32'h4);
        check("t2_lat0", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        check("t2_re1", {28'd0, read_enable}, 32'h4);
        check("t2_lat1", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        check("t2_re2", {28'd0, read_enable}, 32'h4);
        check("t2_lat2", {31'd0, valid_out}, 32'd1);
        @(negedge clk);
        check("t2_re3", {28'd0, read_enable}, 32'd0);
        repeat (3) @(negedge clk);
        check("t2_idle", {30'd0, state}, 32'd0);
        check("t2_drained", exp_q.size(), 32'd0);
        do_reset();

        // Test 3: all four FIFOs, two words each
        load_all(2);
        for (int w = 0; w < 2; w++)
            for (int f = 0; f < 4; f++) exp_q.push_back({2'(f), mkw(f, w)});
        channel_enable = 4'hF;
        wait_re("t3");
        for (int k = 0; k < 8; k++) begin
            check("t3_re", {28'd0, read_enable}, 32'd1 << (k % 4));
            @(negedge clk);
        end
        check("t3_re_end", {28'd0, read_enable}, 32'd0);
        repeat (4) @(negedge clk);
        check("t3_drained", exp_q.size(), 32'd0);
        do_reset();

        // Test 4: backpressure after two pops, pointer preserved
        load_all(2);
        for (int w = 0; w < 2; w++)
            for (int f = 0; f < 4; f++) exp_q.push_back({2'(f), mkw(f, w)});
        channel_enable = 4'hF;
        wait_re("t4");
        check("t4_re0", {28'd0, read_enable}, 32'h1);
        @(negedge clk);
        check("t4_re1", {28'd0, read_enable}, 32'h2);
        @(negedge clk);
        down_almost_full = 1'b1;
        #1 check("t4_re_blocked", {28'd0, read_enable}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_stall_state", {30'd0, state}, 32'd2);
            check("t4_stall_re", {28'd0, read_enable}, 32'd0);
        end
        check("t4_inflight_out", exp_q.size(), 32'd6);
        down_almost_full = 1'b0;
        wait_re("t4_resume");
        check("t4_resume_re", {28'd0, read_enable}, 32'h4);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            check("t4_re_tail", {28'd0, read_enable}, 32'd1 << ((k + 2) % 4));
        end
        repeat (4) @(negedge clk);
        check("t4_drained", exp_q.size(), 32'd0);
        do_reset();

        // Test 5: channel 2 disabled
        load_all(2);
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back({2'd0, mkw(0, w)});
            exp_q.push_back({2'd1, mkw(1, w)});
            exp_q.push_back({2'd3, mkw(3, w)});
        end
        channel_enable = 4'b1011;
        saw2 = 1'b0;
        wait_re("t5");
        for (int k = 0; k < 6; k++) begin
            check("t5_re", {28'd0, read_enable}, (k % 3 == 2) ? 32'h8 : (32'd1 << (k % 3)));
            saw2 = saw2 | read_enable[2];
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            saw2 = saw2 | read_enable[2];
            @(negedge clk);
        end
        check("t5_no_fifo2", {31'd0, saw2}, 32'd0);
        check("t5_idle", {30'd0, state}, 32'd0);
        check("t5_drained", exp_q.size(), 32'd0);
        do_reset();

        // Test 6: one-cycle error pulse is sticky until reset
        put(0, mkw(0, 0));
        put(1, mkw(1, 0));
        fifo_error = 4'b0010;
        @(negedge clk);
        fifo_error = 4'd0;
        check("t6_state", {30'd0, state}, 32'd3);
        check("t6_err", {31'd0, error_out}, 32'd1);
        channel_enable = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t6_re_blocked", {28'd0, read_enable}, 32'd0);
        end
        check("t6_state_held", {30'd0, state}, 32'd3);
        check("t6_err_held", {31'd0, error_out}, 32'd1);
        do_reset();

        // Test 7: word in flight drains after entering ERROR
        put(0, 10'h2A5);
        exp_q.push_back({2'd0, 10'h2A5});
        channel_enable = 4'h1;
        wait_re("t7");
        fifo_error = 4'b0001;
        @(negedge clk);
        fifo_error = 4'd0;
        check("t7_state", {30'd0, state}, 32'd3);
        check("t7_re", {28'd0, read_enable}, 32'd0);
        @(negedge clk);
        check("t7_drain_valid", {31'd0, valid_out}, 32'd1);
        repeat (2) @(negedge clk);
        check("t7_drained", exp_q.size(), 32'd0);
        do_reset();

        check("no_bad_pop", {31'd0, bad_rd}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
